mf_frame_ctrl: RTL and testbench
================================

Name: mf_frame_ctrl

Overview:
- AXI-Stream frame sequencer placed in front of the MeanFilter input.
- Locks to start-of-frame (SOF) and counts columns and rows, regenerating clean tuser/tlast framing.
- Drives the filter's in_valid qualifier and injects the flush lines the window needs to emit its last output rows.
- Reports framing errors; frames are gated by a software enable sampled only at frame boundaries.

Parameters:
DATA_WIDTH, 8, pixel width
FRAME_WIDTH, 640, pixels per line
FRAME_HEIGHT, 512, lines per frame
WINDOW_SIZE, 3, filter window (odd); flush lines FL = WINDOW_SIZE/2 (integer)
PAD_VALUE, 0, pixel value driven during flush

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  allow frames; sampled in IDLE only
err_clear  in  1  one-cycle pulse, clears sticky errors
s_axis_tdata  in  DATA_WIDTH  upstream pixel
s_axis_tvalid  in  1  upstream valid
s_axis_tlast  in  1  upstream end of line
s_axis_tuser  in  1  upstream SOF
s_axis_tready  out  1  ready to upstream
m_axis_tdata  out  DATA_WIDTH  pixel to filter
m_axis_tvalid  out  1  valid to filter
m_axis_tlast  out  1  regenerated end of line
m_axis_tuser  out  1  regenerated SOF
m_axis_tready  in  1  filter ready
in_valid  out  1  1 = real pixel, 0 = flush pad
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of FLUSH
err_line  out  1  sticky: input tlast disagrees with column count
err_sof  out  1  sticky: SOF seen mid-frame

Behaviour:
- Reset (synchronous) from any state:
  - state=IDLE; col=row=0.
  - All outputs 0: s_axis_tready, m_axis_tvalid, m_axis_tdata, tlast, tuser, in_valid, busy, frame_done, err_line, err_sof.
  - A frame in flight is abandoned with no flush.
- Transfer rule: a beat transfers when valid&&ready on the respective side. col/row advance only on m-side transfers.
- States: IDLE, ACTIVE, FLUSH.
- IDLE:
  - Upstream is drained: s_axis_tready=enable; m_axis_tvalid=0.
  - A beat accepted without tuser is dropped.
  - A beat with tuser while enable=1 is not consumed in IDLE: s_axis_tready drops combinationally when s_axis_tuser=1. The next cycle moves to ACTIVE with col=row=0.
- ACTIVE, combinational pass-through with zero latency:
  - m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready; m_axis_tdata=s_axis_tdata; in_valid=1.
  - m_axis_tuser=(col==0&&row==0); m_axis_tlast=(col==FRAME_WIDTH-1), from the counter, never from the input.
  - Counter: col wraps at FRAME_WIDTH-1 and increments row.
  - Transfer at row==FRAME_HEIGHT-1, col==FRAME_WIDTH-1: next state FLUSH, col=row=0.
- ACTIVE error handling:
  - Input tlast!=(col==FRAME_WIDTH-1) on a transfer: set err_line; counters are not altered.
  - Input tuser on a transfer with (col,row)!=(0,0): set err_sof; the beat becomes pixel (0,0) (m_axis_tuser=1, col=1, row=0), i.e. the frame restarts.
- FLUSH:
  - s_axis_tready=0; m_axis_tvalid=1; m_axis_tdata=PAD_VALUE; in_valid=0; m_axis_tuser=0; m_axis_tlast=(col==FRAME_WIDTH-1).
  - Sends FL*FRAME_WIDTH beats.
  - After the last transfer: frame_done=1 for one cycle; state=IDLE.
  - If FL==0, FLUSH is skipped: frame_done pulses on the cycle after the last ACTIVE transfer.
- Backpressure: m_axis_tready=0 holds all m-side outputs stable; counters and state frozen.
- Errors:
  - err_clear clears both sticky errors.
  - Set has priority over clear in the same cycle.
- Boundaries:
  - enable falling mid-frame: has no effect until IDLE.
  - enable low in IDLE: s_axis_tready=0, upstream stalls.
- Widths: col is $clog2(FRAME_WIDTH) bits; row is $clog2(FRAME_HEIGHT) bits, wide enough for FL.

Optional Feature:
- Macro MF_FRAME_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] and drop_cnt[15:0].
  - frame_cnt increments on each frame_done.
  - drop_cnt increments on each beat dropped in IDLE.
  - Both saturate at 16'hFFFF, reset to 0 by rst, and are cleared by err_clear.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Nominal frame, default params, m_axis_tready=1:
  - 327680 beats pass through with tuser only on beat 0 and tlast every 640th beat.
  - Then 640 flush beats with data=0, in_valid=0, tlast on the last.
  - frame_done pulses once; busy returns 0; no errors.
- Pre-SOF garbage: 5 beats without tuser, then a frame:
  - The 5 beats are dropped (never seen on m-side); drop_cnt=5 when MF_FRAME_STATS_EN.
  - The frame is forwarded intact.
- Short line: input tlast on col 100 of row 3:
  - err_line=1; m_axis_tlast still only at col 639.
  - err_clear then clears err_line to 0.
- Mid-frame SOF at row 10, col 5:
  - err_sof=1; that beat exits with m_axis_tuser=1.
  - Frame completes after 327680 beats counted from it.
- Random m_axis_tready (50%) over a frame plus flush:
  - m-side data/tlast/tuser are stable while stalled.
  - Output sequence is identical to the nominal case.
- Reset asserted at row 200 mid-frame:
  - Next cycle all outputs are 0 and state is IDLE.
  - No flush; the next SOF frame is processed normally.

Source files
------------

// File: rtl/mf_frame_ctrl.sv
// mf_frame_ctrl: AXI-Stream frame sequencer in front of the MeanFilter.
//
// Locks to SOF (tuser), counts columns/rows and regenerates clean tuser/tlast
// for the filter. After the last pixel of a frame, it injects FL = WINDOW_SIZE/2
// flush lines of PAD_VALUE so the window can emit its final output rows.
// Framing errors are sticky. The software enable is only honoured in IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              accept new frames (sampled in IDLE only)
//   err_clear           pulse: clears sticky errors (and stats counters)
//   s_axis_*            upstream pixel stream (tdata/tvalid/tlast/tuser/tready)
//   m_axis_*            stream to the filter (tdata/tvalid/tlast/tuser/tready)
//   in_valid            1 = real pixel, 0 = flush pad
//   busy                frame in progress (state != IDLE)
//   frame_done          one-cycle pulse once the frame and its flush are sent
//   err_line, err_sof   sticky: input tlast mismatch / SOF seen mid-frame
//
// Optional build macro MF_FRAME_STATS_EN adds frame_cnt[15:0] and
// drop_cnt[15:0] (saturating, cleared by rst or err_clear).
module mf_frame_ctrl #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          FRAME_WIDTH  = 640,
  parameter int          FRAME_HEIGHT = 512,
  parameter int          WINDOW_SIZE  = 3,
  parameter int unsigned PAD_VALUE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  err_clear,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  in_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_line,
  output logic                  err_sof
`ifdef MF_FRAME_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int FL   = WINDOW_SIZE / 2;
  localparam int CW   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int RW_H = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int RW_F = $clog2(FL + 1);
  localparam int RW   = (RW_H > RW_F) ? RW_H : RW_F;
  localparam int FL_LAST_I = (FL > 0) ? FL - 1 : 0;

  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [RW-1:0] FL_LAST  = RW'(FL_LAST_I);
  localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(PAD_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            err_line_q, err_line_d;
  logic            err_sof_q, err_sof_d;
  logic            line_set, sof_set, drop;

  // A mid-frame SOF turns the current beat into pixel (0,0) of a new frame,
  // so every decision on this beat uses the effective position.
  logic            restart;
  logic [CW-1:0]   eff_col;
  logic [RW-1:0]   eff_row;
  logic            eff_last;

  assign restart  = s_axis_tuser && ((col_q != '0) || (row_q != '0));
  assign eff_col  = restart ? '0 : col_q;
  assign eff_row  = restart ? '0 : row_q;
  assign eff_last = (eff_col == COL_LAST);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
      err_line_q <= 1'b0;
      err_sof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
      err_line_q <= err_line_d;
      err_sof_q  <= err_sof_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    done_d   = 1'b0;
    line_set = 1'b0;
    sof_set  = 1'b0;
    drop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Non-SOF beats are drained; the SOF beat stays upstream for ACTIVE.
        drop = enable && s_axis_tvalid && !s_axis_tuser;
        if (enable && s_axis_tvalid && s_axis_tuser) begin
          state_d = S_ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (s_axis_tvalid && m_axis_tready) begin
          line_set = (s_axis_tlast != eff_last);
          sof_set  = restart;
          if (eff_last) begin
            col_d = '0;
            if (eff_row == ROW_LAST) begin
              row_d = '0;
              if (FL == 0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = S_FLUSH;
              end
            end else begin
              row_d = eff_row + 1'b1;
            end
          end else begin
            col_d = eff_col + 1'b1;
            row_d = eff_row;
          end
        end
      end
      S_FLUSH: begin
        // row_q counts flush lines here.
        if (m_axis_tready) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == FL_LAST) begin
              row_d   = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sticky errors: set wins over clear.
    err_line_d = line_set ? 1'b1 : (err_clear ? 1'b0 : err_line_q);
    err_sof_d  = sof_set  ? 1'b1 : (err_clear ? 1'b0 : err_sof_q);
  end

  // Outputs. Combinational outputs are forced low while rst is held so the
  // block looks quiet even before the reset edge lands.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    in_valid      = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: s_axis_tready = enable && !s_axis_tuser;
        S_ACTIVE: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tuser  = (eff_col == '0) && (eff_row == '0);
          m_axis_tlast  = eff_last;
          in_valid      = 1'b1;
        end
        S_FLUSH: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = PAD;
          m_axis_tlast  = (col_q == COL_LAST);
        end
        default: ;
      endcase
    end
  end

  assign frame_done = done_q;
  assign err_line   = err_line_q;
  assign err_sof    = err_sof_q;

`ifdef MF_FRAME_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || err_clear) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF))    drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mf_frame_ctrl.sv
module tb_mf_frame_ctrl;
  localparam int FW  = 8;
  localparam int FH  = 6;
  localparam int WS  = 5;
  localparam int FL  = WS / 2;
  localparam logic [7:0] PAD = 8'hA5;

  logic clk, rst, enable, err_clear;
  logic [7:0] s_tdata, m_tdata;
  logic s_tvalid, s_tlast, s_tuser, s_tready;
  logic m_tvalid, m_tlast, m_tuser, m_tready;
  logic in_valid, busy, frame_done, err_line, err_sof;
`ifdef MF_FRAME_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  mf_frame_ctrl #(.DATA_WIDTH(8), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                  .WINDOW_SIZE(WS), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clear(err_clear),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .in_valid(in_valid), .busy(busy), .frame_done(frame_done),
    .err_line(err_line), .err_sof(err_sof)
`ifdef MF_FRAME_STATS_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; logic u; } in_t;
  typedef struct { logic [7:0] d; logic l; logic u; logic iv; logic fin; } exp_t;
  typedef struct { logic en; logic v; logic u; logic rdy; } vec_t;

  in_t  in_q[$];
  exp_t exp_q[$];
  int   tot_cnt = 0, pass_cnt = 0;
  int   fd_cnt = 0, mcount = 0;
  bit   pres = 0, manual = 0, rnd_mode = 0, s_xfer_n = 0;
  bit   fin_prev = 0, stall_prev = 0;
  logic [11:0] stall_snap;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: a frame is FW*FH pixels with tuser on pixel 0 and tlast every
  // FW-th pixel, followed by FL*FW pad beats; a partial frame has no pads.
  task automatic add_frame(input int npix, input int bad);
    in_t b; exp_t e;
    for (int i = 0; i < npix; i++) begin
      b.d = 8'($urandom);
      b.u = (i == 0);
      b.l = ((i % FW) == FW - 1) ^ (i == bad);
      in_q.push_back(b);
      e.d = b.d; e.l = ((i % FW) == FW - 1); e.u = (i == 0); e.iv = 1'b1; e.fin = 1'b0;
      exp_q.push_back(e);
    end
    if (npix == FW * FH)
      for (int j = 0; j < FL * FW; j++) begin
        e.d = PAD; e.l = ((j % FW) == FW - 1); e.u = 1'b0; e.iv = 1'b0;
        e.fin = (j == FL * FW - 1);
        exp_q.push_back(e);
      end
  endtask

  // Upstream driver (AXI-compliant: a presented beat is held until taken)
  always @(posedge clk) begin
    #1;
    if (!manual) begin
      if (s_xfer_n && pres) begin
        if (in_q.size() > 0) void'(in_q.pop_front());
        pres = 0;
      end
      if (!pres && in_q.size() > 0 && (!rnd_mode || $urandom_range(3) != 0)) pres = 1;
      if (pres) begin
        s_tvalid = 1'b1; s_tdata = in_q[0].d; s_tlast = in_q[0].l; s_tuser = in_q[0].u;
      end else begin
        s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'b0; s_tuser = 1'b0;
      end
    end
    m_tready = rnd_mode ? 1'($urandom_range(1)) : 1'b1;
  end

  // Monitor: compare every m-side transfer against the reference queue
  always @(negedge clk) begin
    exp_t e;
    s_xfer_n = s_tvalid && s_tready;
    if (frame_done || fin_prev) chk("frame_done", frame_done, fin_prev);
    if (frame_done) fd_cnt++;
    fin_prev = 0;
    if (stall_prev)
      chk("stall_stable", {m_tvalid, m_tdata, m_tlast, m_tuser, in_valid}, stall_snap);
    if (m_tvalid && m_tready) begin
      mcount++;
      if (exp_q.size() == 0) chk("extra_beat", {m_tdata, m_tlast, m_tuser}, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat", {m_tdata, m_tlast, m_tuser, in_valid}, {e.d, e.l, e.u, e.iv});
        fin_prev = e.fin;
      end
    end
    stall_prev = m_tvalid && !m_tready;
    stall_snap = {m_tvalid, m_tdata, m_tlast, m_tuser, in_valid};
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0 || busy || pres) && n < 4000) begin
      @(negedge clk); n++;
    end
    chk(nm, n < 4000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2 err_clear = 1'b1;
    @(posedge clk); #2 err_clear = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int n;
    vt[0] = '{en:0, v:0, u:0, rdy:0};
    vt[1] = '{en:0, v:1, u:0, rdy:0};
    vt[2] = '{en:0, v:1, u:1, rdy:0};
    vt[3] = '{en:1, v:0, u:0, rdy:1};
    vt[4] = '{en:1, v:1, u:0, rdy:1};
    vt[5] = '{en:1, v:0, u:1, rdy:0};

    rst = 1'b1; enable = 1'b1; err_clear = 1'b0; m_tready = 1'b1;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0; s_tuser = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_side", {m_tvalid, m_tdata, m_tlast, m_tuser, in_valid}, 0);
    chk("rst_status", {busy, frame_done, err_line, err_sof}, 0);
    @(posedge clk); #2 rst = 1'b0;

    // IDLE handshake table
    manual = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable = vt[i].en; s_tvalid = vt[i].v; s_tuser = vt[i].u; s_tlast = 1'b0;
      #1 chk("idle_vec", {s_tready, m_tvalid, busy, in_valid}, {vt[i].rdy, 3'b000});
    end
    @(negedge clk);
    s_tvalid = 0; s_tuser = 0; enable = 1'b1;
    manual = 0;
    @(negedge clk);

    // Nominal frame
    add_frame(FW * FH, -1);
    wait_idle("nominal_drain");
    chk("nominal_errs", {err_line, err_sof, busy}, 0);

    // Pre-SOF garbage then a frame
    pulse_clear();
    for (int i = 0; i < 5; i++) in_q.push_back('{d: 8'(i + 1), l: 1'b0, u: 1'b0});
    add_frame(FW * FH, -1);
    wait_idle("garbage_drain");
`ifdef MF_FRAME_STATS_EN
    chk("drop_cnt", drop_cnt, 5);
    chk("frame_cnt", frame_cnt, 1);
`endif

    // Short line: input tlast early on row 3 col 5
    add_frame(FW * FH, 3 * FW + 5);
    wait_idle("short_drain");
    chk("err_line_set", {err_line, err_sof}, 2'b10);
    pulse_clear();
    @(negedge clk);
    chk("err_line_clr", err_line, 0);

    // Mid-frame SOF at row 2 col 5 restarts the frame
    add_frame(2 * FW + 5, -1);
    add_frame(FW * FH, -1);
    wait_idle("midsof_drain");
    chk("err_sof_set", {err_line, err_sof}, 2'b01);

    // Random backpressure/gaps, with enable dropped mid-frame
    rnd_mode = 1;
    add_frame(FW * FH, -1);
    add_frame(FW * FH, -1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    chk("en_low_frame_end", n < 4000, 1);
    repeat (5) @(negedge clk);
    chk("en_low_stall", {busy, in_q.size() > 0}, 2'b01);
    enable = 1'b1;
    wait_idle("random_drain");
    rnd_mode = 0;
    repeat (2) @(negedge clk);

    // Reset mid-frame (err_sof is still set from above)
    mcount = 0;
    add_frame(FW * FH, -1);
    n = 0;
    while (mcount < 3 * FW + 2 && n < 4000) begin @(negedge clk); n++; end
    chk("reach_row3", n < 4000, 1);
    @(posedge clk); #2;
    rst = 1'b1; in_q.delete(); exp_q.delete(); pres = 0; s_tvalid = 1'b0; s_tuser = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_m_side", {m_tvalid, m_tdata, m_tlast, m_tuser, in_valid}, 0);
    chk("mid_rst_status", {busy, frame_done, err_line, err_sof}, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {busy, m_tvalid}, 0);
    add_frame(FW * FH, -1);
    wait_idle("post_rst_drain");
    chk("post_rst_errs", {err_line, err_sof}, 0);
    chk("frame_done_count", fd_cnt, 7);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", pass_cnt, tot_cnt);
    $fatal(1, "timeout");
  end
endmodule
